// File: rtl/key_filter_if.sv
// Button-side signal bundle for key_filter: raw key input plus conditioned outputs.
interface key_filter_if;
  logic key_in;
  logic key_flag;
  logic key_state;
  logic key_long;

  modport master (output key_in, input key_flag, input key_state, input key_long);
  modport slave  (input key_in, output key_flag, output key_state, output key_long);
endinterface

// File: rtl/key_filter.sv
// Debounces an active-low push-button into a one-cycle key_flag pulse, a clean
// pressed level, and optional long-press auto-repeat, all in the vga_clk domain.
module key_filter #(
  parameter int unsigned CNT_MAX    = 500_000,
  parameter int unsigned HOLD_MAX   = 12_500_000,
  parameter int unsigned REPEAT_MAX = 2_500_000,
  parameter bit          REPEAT_EN  = 1'b1,
  parameter int unsigned CNT_W      = 24
) (
  input  logic         vga_clk,
  input  logic         sys_rst_n,
  key_filter_if.slave  key
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_FILT,
    HELD,
    REPEAT,
    REL_FILT
  } state_t;

  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             sync1, sync2;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ret_repeat, ret_repeat_n;
  logic             flag_q, flag_n;
  logic             level_q, level_n;
  logic             long_q, long_n;

  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      ret_repeat <= 1'b0;
      flag_q     <= 1'b0;
      level_q    <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      sync1      <= key.key_in;
      sync2      <= sync1;
      state      <= state_n;
      cnt        <= cnt_n;
      ret_repeat <= ret_repeat_n;
      flag_q     <= flag_n;
      level_q    <= level_n;
      long_q     <= long_n;
    end
  end

  // A sync2 change always wins over a terminal count, so a bounce on the
  // same cycle as expiry restarts the filter instead of emitting a flag.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    ret_repeat_n = ret_repeat;
    flag_n       = 1'b0;
    level_n      = level_q;
    long_n       = long_q;
    case (state)
      IDLE: begin
        if (!sync2) begin
          state_n = PRESS_FILT;
          cnt_n   = CNT_ONE;
        end else begin
          cnt_n   = '0;
        end
      end
      PRESS_FILT: begin
        if (sync2) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == FILT_LAST) begin
          state_n = HELD;
          cnt_n   = '0;
          flag_n  = 1'b1;
          level_n = 1'b1;
        end else begin
          cnt_n   = cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (sync2) begin
          state_n      = REL_FILT;
          cnt_n        = CNT_ONE;
          ret_repeat_n = 1'b0;
        end else if (cnt == HOLD_LAST) begin
          state_n = REPEAT;
          cnt_n   = '0;
          long_n  = 1'b1;
          flag_n  = REPEAT_EN;
        end else begin
          cnt_n   = cnt + CNT_ONE;
        end
      end
      REPEAT: begin
        if (sync2) begin
          state_n      = REL_FILT;
          cnt_n        = CNT_ONE;
          ret_repeat_n = 1'b1;
        end else if (cnt == REP_LAST) begin
          cnt_n  = '0;
          flag_n = REPEAT_EN;
        end else begin
          cnt_n  = cnt + CNT_ONE;
        end
      end
      REL_FILT: begin
        if (!sync2) begin
          state_n = ret_repeat ? REPEAT : HELD;
          cnt_n   = '0;
        end else if (cnt == FILT_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
          level_n = 1'b0;
          long_n  = 1'b0;
        end else begin
          cnt_n   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign key.key_flag  = flag_q;
  assign key.key_state = level_q;
  assign key.key_long  = long_q;

endmodule

// File: tb/tb_key_filter.sv
// Scoreboard bench for key_filter: two instances (auto-repeat on/off) share one
// random key stream; a run-length reference model predicts every cycle's outputs.
module tb_key_filter;
  localparam int CNT_MAX    = 10;
  localparam int HOLD_MAX   = 50;
  localparam int REPEAT_MAX = 20;
  localparam int CNT_W      = 8;

  logic vga_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic key_in    = 1'b1;

  key_filter_if kif_r ();
  key_filter_if kif_n ();
  assign kif_r.key_in = key_in;
  assign kif_n.key_in = key_in;

  key_filter #(.CNT_MAX(CNT_MAX), .HOLD_MAX(HOLD_MAX), .REPEAT_MAX(REPEAT_MAX),
               .REPEAT_EN(1'b1), .CNT_W(CNT_W))
    dut_r (.vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .key(kif_r));

  key_filter #(.CNT_MAX(CNT_MAX), .HOLD_MAX(HOLD_MAX), .REPEAT_MAX(REPEAT_MAX),
               .REPEAT_EN(1'b0), .CNT_W(CNT_W))
    dut_n (.vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .key(kif_n));

  always #5 vga_clk = ~vga_clk;

  // index 0 = repeat-enabled instance, index 1 = repeat-disabled instance
  typedef struct packed {
    logic [1:0] flag;
    logic [1:0] lvl;
    logic [1:0] lng;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   flag_cnt [2];

  // Reference model: pressed/released decided by run lengths of the
  // synchronized level; hold timer counts low cycles since the last restart.
  initial begin : model
    logic p1, p2, s;
    bit   pressed [2];
    bit   lng [2];
    int   low_run [2];
    int   high_run [2];
    int   timer [2];
    exp_t e;
    p1 = 1'b1;
    p2 = 1'b1;
    for (int v = 0; v < 2; v++) begin
      pressed[v] = 0; lng[v] = 0; low_run[v] = 0; high_run[v] = 0; timer[v] = 0;
    end
    forever begin
      @(posedge vga_clk);
      e = '0;
      if (!sys_rst_n) begin
        p1 = 1'b1;
        p2 = 1'b1;
        for (int v = 0; v < 2; v++) begin
          pressed[v] = 0; lng[v] = 0; low_run[v] = 0; high_run[v] = 0; timer[v] = 0;
        end
      end else begin
        s = p2;
        for (int v = 0; v < 2; v++) begin
          if (!pressed[v]) begin
            if (!s) begin
              low_run[v]++;
              if (low_run[v] == CNT_MAX) begin
                pressed[v] = 1; e.flag[v] = 1'b1;
                timer[v] = 0; low_run[v] = 0; high_run[v] = 0;
              end
            end else begin
              low_run[v] = 0;
            end
          end else if (s) begin
            high_run[v]++;
            if (high_run[v] == CNT_MAX) begin
              pressed[v] = 0; lng[v] = 0; high_run[v] = 0;
            end
          end else if (high_run[v] != 0) begin
            high_run[v] = 0;
            timer[v] = 0;
          end else begin
            timer[v]++;
            if (!lng[v] && timer[v] == HOLD_MAX) begin
              lng[v] = 1; timer[v] = 0; e.flag[v] = (v == 0);
            end else if (lng[v] && timer[v] == REPEAT_MAX) begin
              timer[v] = 0; e.flag[v] = (v == 0);
            end
          end
          e.lvl[v] = pressed[v];
          e.lng[v] = lng[v];
        end
        p2 = p1;
        p1 = key_in;
      end
      exp_q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    exp_t got;
    logic [1:0] prev_flag;
    prev_flag = 2'b00;
    flag_cnt[0] = 0;
    flag_cnt[1] = 0;
    forever begin
      @(negedge vga_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got.flag = {kif_n.key_flag, kif_r.key_flag};
        got.lvl  = {kif_n.key_state, kif_r.key_state};
        got.lng  = {kif_n.key_long, kif_r.key_long};
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL outputs t=%0t flag=%b state=%b long=%b expected flag=%b state=%b long=%b",
                   $time, got.flag, got.lvl, got.lng, e.flag, e.lvl, e.lng);
        end
        checks++;
        if ((prev_flag & got.flag) != 2'b00) begin
          failures++;
          $display("FAIL flag_twice t=%0t flag=%b prev=%b expected no back-to-back",
                   $time, got.flag, prev_flag);
        end
        prev_flag = got.flag;
        for (int v = 0; v < 2; v++) if (got.flag[v] === 1'b1) flag_cnt[v]++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge vga_clk);
      #1;
    end
  endtask

  task automatic chk_flags(input string name, input int base_r, input int base_n,
                           input int want_r, input int want_n);
    checks++;
    if (flag_cnt[0] - base_r != want_r) begin
      failures++;
      $display("FAIL %s_rep flags=%0d expected=%0d", name, flag_cnt[0] - base_r, want_r);
    end
    checks++;
    if (flag_cnt[1] - base_n != want_n) begin
      failures++;
      $display("FAIL %s_norep flags=%0d expected=%0d", name, flag_cnt[1] - base_n, want_n);
    end
  endtask

  initial begin : stimulus
    int br, bn;
    sys_rst_n = 1'b0;
    key_in    = 1'b1;
    cyc(3);
    sys_rst_n = 1'b1;
    br = flag_cnt[0]; bn = flag_cnt[1];
    cyc(100);
    chk_flags("reset_idle", br, bn, 0, 0);

    br = flag_cnt[0]; bn = flag_cnt[1];
    key_in = 1'b0; cyc(30);
    key_in = 1'b1; cyc(40);
    chk_flags("clean_press", br, bn, 1, 1);

    br = flag_cnt[0]; bn = flag_cnt[1];
    key_in = 1'b0; cyc(5);
    key_in = 1'b1; cyc(2);
    key_in = 1'b0; cyc(5);
    key_in = 1'b1; cyc(3);
    key_in = 1'b0; cyc(30);
    key_in = 1'b1; cyc(40);
    chk_flags("bounce", br, bn, 1, 1);

    br = flag_cnt[0]; bn = flag_cnt[1];
    key_in = 1'b0; cyc(190);
    key_in = 1'b1; cyc(40);
    chk_flags("long_press", br, bn, 8, 1);

    br = flag_cnt[0]; bn = flag_cnt[1];
    key_in = 1'b0; cyc(30);
    key_in = 1'b1; cyc(4);
    key_in = 1'b0; cyc(45);
    key_in = 1'b1; cyc(40);
    chk_flags("release_bounce", br, bn, 1, 1);

    br = flag_cnt[0]; bn = flag_cnt[1];
    key_in = 1'b0; cyc(80);
    sys_rst_n = 1'b0; cyc(2);
    sys_rst_n = 1'b1; cyc(30);
    key_in = 1'b1; cyc(40);
    chk_flags("reset_mid_repeat", br, bn, 3, 2);

    for (int i = 0; i < 120; i++) begin
      key_in = ~key_in;
      if ($urandom_range(0, 2) == 0) cyc($urandom_range(1, 12));
      else cyc($urandom_range(13, 150));
      if ($urandom_range(0, 19) == 0) begin
        sys_rst_n = 1'b0;
        cyc($urandom_range(1, 3));
        sys_rst_n = 1'b1;
      end
    end
    key_in = 1'b1;
    cyc(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
